// File: rtl/tstate_seq.sv
// T-state / machine-cycle sequencer: steps T-states, counts machine cycles, inserts waits, arbitrates HOLD, handles HALT.
// Optional macro TSEQ_AUTOWAIT_EN adds the auto-wait counter (AUTO_WAIT forced waits after T2 of non-idle cycles).
module tstate_seq #(
  parameter int unsigned MCW       = 3,
  parameter int unsigned AWW       = 4,
  parameter int unsigned AUTO_WAIT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ready,
  input  logic           bimc,
  input  logic           hold,
  input  logic           dec_vld,
  input  logic [MCW-1:0] dec_mcnt,
  input  logic           dec_six,
  input  logic           dec_halt,
  input  logic           resume,
  output logic [3:0]     tstate,
  output logic [MCW-1:0] mcycle,
  output logic           fmc,
  output logic           lmc,
  output logic           ale,
  output logic           hlda
);

  typedef enum logic [3:0] {
    TR = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4,
    T5 = 4'd5, T6 = 4'd6, TH = 4'd7, TW = 4'd8, TT = 4'd9
  } tstate_e;

  tstate_e        state_q, state_d;
  logic [MCW-1:0] mcycle_q, mcycle_d;
  logic [MCW-1:0] mcnt_q, mcnt_d;
  logic           six_q, six_d;
  logic           halt_q, halt_d;
  logic           ret_tt_q, ret_tt_d;
  logic           wz;
  logic           eoc, adv, new_m1;
  logic [MCW-1:0] mcnt_eff;

`ifdef TSEQ_AUTOWAIT_EN
  logic [AWW-1:0] wcnt_q, wcnt_d;

  assign wz = (wcnt_q == '0);

  always_comb begin
    wcnt_d = wcnt_q;
    if (state_q == T1)
      wcnt_d = bimc ? '0 : AWW'(AUTO_WAIT);
    else if ((state_q == T2 || state_q == TW) && !wz)
      wcnt_d = wcnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) wcnt_q <= '0;
    else      wcnt_q <= wcnt_d;
  end
`else
  assign wz = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= TR;
      mcycle_q <= MCW'(1);
      mcnt_q   <= '0;
      six_q    <= 1'b0;
      halt_q   <= 1'b0;
      ret_tt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcycle_q <= mcycle_d;
      mcnt_q   <= mcnt_d;
      six_q    <= six_d;
      halt_q   <= halt_d;
      ret_tt_q <= ret_tt_d;
    end
  end

  // End-of-cycle resolution is shared by T3/T4/T6; TH exit reuses the same advance path.
  always_comb begin
    state_d  = state_q;
    mcycle_d = mcycle_q;
    mcnt_d   = mcnt_q;
    six_d    = six_q;
    halt_d   = halt_q;
    ret_tt_d = ret_tt_q;
    eoc      = 1'b0;
    adv      = 1'b0;
    new_m1   = 1'b0;
    case (state_q)
      TR: begin
        state_d  = T1;
        mcycle_d = MCW'(1);
        new_m1   = 1'b1;
      end
      T1: state_d = T2;
      T2, TW: begin
        if ((ready | bimc) && wz) state_d = T3;
        else                      state_d = TW;
      end
      T3: begin
        if (fmc) begin
          state_d = T4;
          if (dec_vld) begin
            mcnt_d = dec_mcnt;
            six_d  = dec_six;
            halt_d = dec_halt;
          end
        end else begin
          eoc = 1'b1;
        end
      end
      T4: begin
        if (six_q) state_d = T5;
        else       eoc     = 1'b1;
      end
      T5: state_d = T6;
      T6: eoc = 1'b1;
      TH: begin
        if (!hold) begin
          if (ret_tt_q) state_d = TT;
          else          adv     = 1'b1;
        end
      end
      TT: begin
        if (hold) begin
          state_d  = TH;
          ret_tt_d = 1'b1;
        end else if (resume) begin
          state_d  = T1;
          mcycle_d = MCW'(1);
          new_m1   = 1'b1;
        end
      end
      default: state_d = TR;
    endcase

    if (eoc) begin
      if (hold) begin
        state_d  = TH;
        ret_tt_d = lmc & halt_q;
      end else if (lmc && halt_q) begin
        state_d = TT;
      end else begin
        adv = 1'b1;
      end
    end

    if (adv) begin
      state_d = T1;
      if (lmc) begin
        mcycle_d = MCW'(1);
        new_m1   = 1'b1;
      end else begin
        mcycle_d = mcycle_q + MCW'(1);
      end
    end

    if (new_m1) begin
      mcnt_d = '0;
      six_d  = 1'b0;
      halt_d = 1'b0;
    end
  end

  // A latched count of zero means a single-cycle instruction.
  always_comb begin
    mcnt_eff = (mcnt_q == '0) ? MCW'(1) : mcnt_q;
    tstate   = state_q;
    mcycle   = mcycle_q;
    fmc      = (mcycle_q == MCW'(1));
    ale      = (state_q == T1);
    hlda     = (state_q == TH);
    lmc      = (mcycle_q == mcnt_eff) &&
               !(fmc && (state_q == TR || state_q == T1 || state_q == T2 ||
                         state_q == TW || state_q == T3));
  end

endmodule

// File: tb/tb_tstate_seq.sv
// Scoreboard bench for tstate_seq: stimulus queues per-clock expected state, a monitor pops and compares.
module tb_tstate_seq;
  localparam int MCW = 3;
`ifdef TSEQ_AUTOWAIT_EN
  localparam int AW = 2;
`else
  localparam int AW = 0;
`endif
  localparam int S_TR = 0, S_T1 = 1, S_T2 = 2, S_T3 = 3, S_T4 = 4,
                 S_T5 = 5, S_T6 = 6, S_TH = 7, S_TW = 8, S_TT = 9;

  logic           clk, rst, ready, bimc, hold, dec_vld, dec_six, dec_halt, resume;
  logic [MCW-1:0] dec_mcnt;
  logic [3:0]     tstate;
  logic [MCW-1:0] mcycle;
  logic           fmc, lmc, ale, hlda;

  tstate_seq #(.MCW(MCW), .AWW(4), .AUTO_WAIT(2)) dut (
    .clk(clk), .rst(rst), .ready(ready), .bimc(bimc), .hold(hold),
    .dec_vld(dec_vld), .dec_mcnt(dec_mcnt), .dec_six(dec_six),
    .dec_halt(dec_halt), .resume(resume), .tstate(tstate), .mcycle(mcycle),
    .fmc(fmc), .lmc(lmc), .ale(ale), .hlda(hlda)
  );

  typedef struct {
    int ts;
    int mc;
    int lm;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("tstate", int'(tstate), e.ts);
        chk("mcycle", int'(mcycle), e.mc);
        chk("fmc",    int'(fmc),    (e.mc == 1) ? 1 : 0);
        chk("ale",    int'(ale),    (e.ts == S_T1) ? 1 : 0);
        chk("hlda",   int'(hlda),   (e.ts == S_TH) ? 1 : 0);
        chk("lmc",    int'(lmc),    e.lm);
      end
    end
  end

  // Queue the state expected after the coming rising edge, then move to the next falling edge.
  task automatic step(input int ts, input int mc, input int lm);
    exp_t e;
    e.ts = ts; e.mc = mc; e.lm = lm;
    q.push_back(e);
    @(negedge clk);
  endtask

  // From T1: T2, waits, T3. ready is held low for rlow samples starting in T2.
  task automatic mid(input int mc, input int lm, input int rlow);
    int nw;
    nw = bimc ? 0 : ((rlow > AW) ? rlow : AW);
    step(S_T2, mc, lm);
    ready = (rlow <= 0);
    for (int i = 0; i < nw; i++) begin
      step(S_TW, mc, lm);
      ready = (rlow <= i + 1);
    end
    step(S_T3, mc, lm);
    ready = 1'b1;
  endtask

  task automatic decode(input int n, input logic six, input logic hlt);
    dec_vld  = 1'b1;
    dec_mcnt = MCW'(n);
    dec_six  = six;
    dec_halt = hlt;
  endtask

  task automatic undecode();
    dec_vld = 1'b0; dec_mcnt = '0; dec_six = 1'b0; dec_halt = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ready = 1'b1; bimc = 1'b0; hold = 1'b0; resume = 1'b0;
    undecode();
    @(negedge clk);
    step(S_TR, 1, 0);
    step(S_TR, 1, 0);
    rst = 1'b1;

    // Three-cycle instruction, no extra waits from ready.
    step(S_T1, 1, 0);
    mid(1, 0, 0);
    decode(3, 1'b0, 1'b0);
    step(S_T4, 1, 0);
    undecode();
    step(S_T1, 2, 0);
    mid(2, 0, 0);
    step(S_T1, 3, 1);
    mid(3, 1, 0);
    step(S_T1, 1, 0);

    // Two-cycle instruction, ready low for two samples in M2.
    mid(1, 0, 0);
    decode(2, 1'b0, 1'b0);
    step(S_T4, 1, 0);
    undecode();
    step(S_T1, 2, 1);
    mid(2, 1, 2);
    step(S_T1, 1, 0);

    // Bus-idle M2 with ready low: no waits at all.
    mid(1, 0, 0);
    decode(2, 1'b0, 1'b0);
    step(S_T4, 1, 0);
    undecode();
    step(S_T1, 2, 1);
    bimc = 1'b1;
    mid(2, 1, 3);
    bimc = 1'b0;
    step(S_T1, 1, 0);

    // Six-state M1, mcnt=0 behaves as 1, hold raised in T5.
    mid(1, 0, 0);
    decode(0, 1'b1, 1'b0);
    step(S_T4, 1, 1);
    undecode();
    step(S_T5, 1, 1);
    hold = 1'b1;
    step(S_T6, 1, 1);
    step(S_TH, 1, 1);
    step(S_TH, 1, 1);
    hold = 1'b0;
    step(S_T1, 1, 0);

    // HLT: T4 -> TT, hold wins over resume, resume exits.
    mid(1, 0, 0);
    decode(1, 1'b0, 1'b1);
    step(S_T4, 1, 1);
    undecode();
    step(S_TT, 1, 1);
    step(S_TT, 1, 1);
    hold = 1'b1;
    step(S_TH, 1, 1);
    step(S_TH, 1, 1);
    hold = 1'b0;
    step(S_TT, 1, 1);
    hold = 1'b1; resume = 1'b1;
    step(S_TH, 1, 1);
    hold = 1'b0; resume = 1'b0;
    step(S_TT, 1, 1);
    step(S_TT, 1, 1);
    resume = 1'b1;
    step(S_T1, 1, 0);
    resume = 1'b0;

    // Reset during TW of M2, then a default (no-strobe) instruction.
    mid(1, 0, 0);
    decode(2, 1'b0, 1'b0);
    step(S_T4, 1, 0);
    undecode();
    step(S_T1, 2, 1);
    ready = 1'b0;
    step(S_T2, 2, 1);
    step(S_TW, 2, 1);
    rst = 1'b0;
    step(S_TR, 1, 0);
    rst = 1'b1; ready = 1'b1;
    step(S_T1, 1, 0);
    mid(1, 0, 0);
    step(S_T4, 1, 1);
    step(S_T1, 1, 0);

    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tstate_seq.md
# tstate_seq

Parametrised T-state / machine-cycle sequencer for the 8085-class core: the next-generation replacement for the fixed control state machine. It sequences T-states within each machine cycle and counts machine cycles per instruction from decode information. It also handles READY/auto-inserted wait states, HOLD arbitration between machine cycles and HALT entry/exit. It sits between the instruction decoder and the bus interface and drives ALE, HLDA and the cycle-position flags.

## Interface
- MCW, 3: machine-cycle counter width; max cycles per instruction = 2^MCW-1
- AWW, 4: auto-wait counter width
- AUTO_WAIT, 0: wait states forced after T2 of every non-idle cycle (0..2^AWW-1); effective only with TSEQ_AUTOWAIT_EN
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- ready  in  1  bus ready, sampled in T2 and TW
- bimc  in  1  current cycle is bus-idle: ignores ready, no waits
- hold  in  1  bus hold request, sampled at end-of-cycle, in TH and in TT
- dec_vld  in  1  decode strobe, sampled only in M1 T3
- dec_mcnt  in  MCW  total machine cycles incl. M1; 0 treated as 1
- dec_six  in  1  M1 runs T1..T6 instead of T1..T4
- dec_halt  in  1  instruction is HLT
- resume  in  1  interrupt/restart exit from halt
- tstate  out  4  TR=0, T1..T6=1..6, TH=7, TW=8, TT=9
- mcycle  out  MCW  current machine cycle, 1 = M1
- fmc  out  1  mcycle==1
- lmc  out  1  last machine cycle; 0 during M1 T1..T3
- ale  out  1  high exactly in T1
- hlda  out  1  high exactly in TH

## Operation
- Latched decode: mcnt (default 1), six (default 0), halt_pend (0). Loaded on dec_vld in M1 T3; no strobe -> defaults. Cleared at start of each new M1.
- TR -> T1 (mcycle=1) after one cycle.
- T1 -> T2 always.
- T2 -> T3 if (ready|bimc) and wcnt==0; else TW. With auto-wait, wcnt loads AUTO_WAIT on entering T2 when bimc=0.
- TW: wcnt decrements while nonzero; -> T3 when wcnt==0 and (ready|bimc).
- T3 -> T4 if fmc, else end-of-cycle. T4 -> T5 if six, else end-of-cycle. T5 -> T6. T6 -> end-of-cycle.
- End-of-cycle priority: hold -> TH (pending target remembered); else lmc and halt_pend -> TT; else lmc -> T1, mcycle=1; else T1, mcycle+1.
- TH: stays while hold; on hold low -> remembered target (T1 of next cycle or TT).
- TT: hold -> TH (target TT); else resume -> T1, mcycle=1, halt_pend cleared; else stay. resume is level-sampled, not latched.

## Timing
- All outputs registered/decoded from state; state and counters update on rising clk.
- Reset: rst low at any edge, any state -> next state TR. tstate=0, mcycle=1, fmc=1, lmc=0, ale=0, hlda=0. mcnt/six/halt_pend/wcnt cleared. Mid-cycle reset abandons the cycle.
- Minimum M1 = 4 clocks (T1..T4), 6 with six; other cycles 3 clocks + waits.
- Wait count per cycle = max(AUTO_WAIT, clocks until ready); bimc cycles never wait.
- HOLD: hlda rises one clock after end-of-cycle T-state; bus regained one clock after hold falls.
- Simultaneous hold and resume in TT: hold wins; resume must still be high on return to TT.
- mcnt=1: lmc asserts from M1 T4; mcnt>1: lmc high only when mcycle==mcnt.

## Configuration
- TSEQ_AUTOWAIT_EN defined: wcnt counter and AUTO_WAIT insertion present.
- Undefined: no wcnt logic; wcnt treated as 0 and waits come only from ready=0; AUTO_WAIT ignored.

## Test plan
- Reset then ready=1, dec_mcnt=3, dec_six=0: tstate 0,1,2,3,4,1,2,3,1,2,3,1; mcycle 1,1,1,1,1,2,2,2,3,3,3,1; lmc high in M3 only.
- ready low 2 clocks in M2 T2: tstate ...2,8,8,3...; bimc=1 with ready=0: no TW.
- TSEQ_AUTOWAIT_EN, AUTO_WAIT=2, ready=1: every non-idle cycle shows 2,8,8,3; bimc cycle shows 2,3.
- dec_six=1, mcnt=1: tstate 1..6 then 1; hold raised during M1 T5: TH after T6, hlda=1, returns to T1 one clock after hold falls.
- dec_halt=1, mcnt=1: T4 -> TT; hold in TT -> TH -> TT; resume=1 -> T1, mcycle=1.
- rst low during TW of M2: next tstate=0, mcycle=1, hlda=0; resumes at T1 with defaults.
